// File: rtl/dcache_pkg.sv
// Shared geometry, address layout and FSM encodings for the direct-mapped data cache.
package dcache_pkg;

  localparam int INDEX_W = 5;
  localparam int OFFS_W  = 5;
  localparam int TAG_W   = 32 - INDEX_W - OFFS_W;
  localparam int LINES   = 1 << INDEX_W;
  localparam int WORDS   = 8;
  localparam int LINE_W  = 256;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WB    = 2'd1;
  localparam logic [1:0] S_ALLOC = 2'd2;

  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [2:0]         word;
    logic [1:0]         byte_off;
  } addr_t;

  function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                            input logic [INDEX_W-1:0] index);
    return {tag, index, {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag and data storage: asynchronous read, one synchronous write port with per-word enables.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic               clk_i,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [LINE_W-1:0]  rd_line,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [WORDS-1:0]   wr_wen,
  input  logic               wr_tag_en,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line
);

  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINE_W-1:0] data_arr [LINES];

  assign rd_tag  = tag_arr[rd_idx];
  assign rd_line = data_arr[rd_idx];

  always_ff @(posedge clk_i) begin
    if (wr_tag_en) tag_arr[wr_idx] <= wr_tag;
    for (int w = 0; w < WORDS; w++) begin
      if (wr_wen[w]) data_arr[wr_idx][w*32 +: 32] <= wr_line[w*32 +: 32];
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller between the MEM stage
// and a block-wide memory; hits complete combinationally, misses stall the pipeline.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_wdata_o,
  input  logic [LINE_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  addr_t              req_a;
  logic [1:0]         state;
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   miss_tag;
  logic [INDEX_W-1:0] miss_idx;
  logic [INDEX_W-1:0] rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic [LINE_W-1:0]  rd_line;
  logic               in_idle, hit, miss, store_hit, fill;
  logic [INDEX_W-1:0] wr_idx;
  logic [WORDS-1:0]   wr_wen;
  logic [LINE_W-1:0]  wr_line;
  logic               unused_byte_off;

  assign req_a           = addr_t'(cpu_addr_i);
  assign unused_byte_off = ^req_a.byte_off;

  // The missing line is latched so the transfer finishes even if the CPU drops its request.
  assign in_idle   = (state == S_IDLE);
  assign rd_idx    = in_idle ? req_a.index : miss_idx;
  assign hit       = cpu_req_i & valid[req_a.index] & (rd_tag == req_a.tag);
  assign miss      = in_idle & cpu_req_i & ~hit;
  assign store_hit = in_idle & hit & cpu_we_i;
  assign fill      = (state == S_ALLOC) & mem_ack_i;

  assign cpu_stall_o = ~in_idle | miss;
  assign cpu_rdata_o = (in_idle & hit & ~cpu_we_i) ? rd_line[{req_a.word, 5'b0} +: 32] : '0;

  assign mem_req_o   = ~in_idle;
  assign mem_we_o    = (state == S_WB);
  assign mem_addr_o  = mem_we_o ? line_addr(rd_tag, miss_idx) : line_addr(miss_tag, miss_idx);
  assign mem_wdata_o = rd_line;

  always_comb begin
    wr_idx  = req_a.index;
    wr_line = {WORDS{cpu_wdata_i}};
    wr_wen  = '0;
    if (fill) begin
      wr_idx  = miss_idx;
      wr_line = mem_rdata_i;
      wr_wen  = '1;
    end else if (store_hit) begin
      wr_wen = WORDS'(1) << req_a.word;
    end
  end

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rd_idx    (rd_idx),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .wr_idx    (wr_idx),
    .wr_wen    (wr_wen),
    .wr_tag_en (fill),
    .wr_tag    (miss_tag),
    .wr_line   (wr_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss) begin
            state <= (valid[req_a.index] & dirty[req_a.index]) ? S_WB : S_ALLOC;
          end else if (store_hit) begin
            dirty[req_a.index] <= 1'b1;
          end
        end
        S_WB: begin
          if (mem_ack_i) state <= S_ALLOC;
        end
        S_ALLOC: begin
          if (mem_ack_i) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (miss) begin
      miss_tag <= req_a.tag;
      miss_idx <= req_a.index;
    end
  end

endmodule
